// File: rtl/bbox_pkg.sv
// Shared types and address helper for the bounding-box scanner and drawer.
// Frame buffer is bottom-up, 3 bytes per pixel, no row padding.
package bbox_pkg;

  localparam int COORD_W         = 11;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  // Byte address of component c of pixel (x,y); row 0 is stored last in memory.
  function automatic logic [31:0] pixel_addr(
    input logic [31:0] width,
    input logic [31:0] height,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] c
  );
    logic [31:0] bpp;
    bpp = 32'(BYTES_PER_PIXEL);
    return (height - 32'd1 - y) * width * bpp + x * bpp + c;
  endfunction

endpackage

// File: rtl/bbox_addr_gen.sv
// Maps a pixel coordinate and colour component onto a frame-buffer byte address.
module bbox_addr_gen
  import bbox_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         c,
  output logic [31:0]        addr
);

  assign addr = pixel_addr(32'(WIDTH), 32'(HEIGHT), 32'(x), 32'(y), 32'(c));

endmodule

// File: rtl/bbox_draw.sv
// Draws a rectangle outline into the frame buffer, one byte write per cycle.
// Define BBOX_FILL_EN to fill the whole box instead of drawing its outline.
module bbox_draw
  import bbox_pkg::*;
#(
  parameter int         WIDTH  = 100,
  parameter int         HEIGHT = 100,
  parameter logic [7:0] COLOR0 = 8'd0,
  parameter logic [7:0] COLOR1 = 8'd0,
  parameter logic [7:0] COLOR2 = 8'd255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               done,
  output logic               err,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic [31:0]        addr,
  output logic [15:0]        wrdata,
  output logic               wren,
  input  logic               wr_ready
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(HEIGHT - 1);
`ifdef BBOX_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  function automatic logic [7:0] colour(input logic [1:0] k);
    case (k)
      2'd0:    return COLOR0;
      2'd1:    return COLOR1;
      default: return COLOR2;
    endcase
  endfunction

  state_t             state;
  logic               arm;   // coordinates captured, validity check pending
  logic [COORD_W-1:0] x_lo, x_hi, y_lo, y_hi;
  logic [COORD_W-1:0] x, y;
  logic [1:0]         c;

  logic [COORD_W-1:0] cx_lo, cx_hi, cy_lo, cy_hi;
  assign cx_lo = (x_min > X_LIM) ? X_LIM : x_min;
  assign cx_hi = (x_max > X_LIM) ? X_LIM : x_max;
  assign cy_lo = (y_min > Y_LIM) ? Y_LIM : y_min;
  assign cy_hi = (y_max > Y_LIM) ? Y_LIM : y_max;

  // Next (x,y,c) after the current transfer; interior rows only visit the two side columns.
  logic [COORD_W-1:0] nx, ny;
  logic [1:0]         nc;
  logic               last;
  logic               full_row;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    nx       = x;
    ny       = y;
    nc       = c + 2'd1;
    last     = 1'b0;
    full_row = FILL || (y == y_lo) || (y == y_hi);
    if (c == 2'd2) begin
      nc = 2'd0;
      if (full_row && (x != x_hi)) begin
        nx = x + 1'b1;
      end else if (!full_row && (x == x_lo) && (x_lo != x_hi)) begin
        nx = x_hi;
      end else begin
        nx   = x_lo;
        ny   = y + 1'b1;
        last = (y == y_hi);
      end
    end
  end

  logic [COORD_W-1:0] gx, gy;
  logic [1:0]         gc;
  logic [31:0]        gaddr;

  always_comb begin
    if (arm) begin
      gx = x_lo;
      gy = y_lo;
      gc = 2'd0;
    end else begin
      gx = nx;
      gy = ny;
      gc = nc;
    end
  end

  bbox_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_addr_gen (
    .x   (gx),
    .y   (gy),
    .c   (gc),
    .addr(gaddr)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      arm    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      wren   <= 1'b0;
      addr   <= '0;
      wrdata <= '0;
      x_lo   <= '0;
      x_hi   <= '0;
      y_lo   <= '0;
      y_hi   <= '0;
      x      <= '0;
      y      <= '0;
      c      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            arm <= 1'b0;
            if ((x_lo > x_hi) || (y_lo > y_hi)) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= WRITE;
              x      <= x_lo;
              y      <= y_lo;
              c      <= 2'd0;
              wren   <= 1'b1;
              addr   <= gaddr;
              wrdata <= {8'h00, colour(2'd0)};
            end
          end else if (start) begin
            state <= IDLE;
            arm   <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            x_lo  <= cx_lo;
            x_hi  <= cx_hi;
            y_lo  <= cy_lo;
            y_hi  <= cy_hi;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              wren  <= 1'b0;
            end else begin
              x      <= nx;
              y      <= ny;
              c      <= nc;
              addr   <= gaddr;
              wrdata <= {8'h00, colour(nc)};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_draw.sv
// Directed bench for bbox_draw (WIDTH=HEIGHT=100, outline unless BBOX_FILL_EN).
module tb_bbox_draw;
  import bbox_pkg::*;

  localparam int W = 100;
  localparam int H = 100;
`ifdef BBOX_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               start    = 1'b0;
  logic               wr_ready = 1'b1;
  logic [COORD_W-1:0] x_min    = '0;
  logic [COORD_W-1:0] x_max    = '0;
  logic [COORD_W-1:0] y_min    = '0;
  logic [COORD_W-1:0] y_max    = '0;
  logic               done, err, wren;
  logic [31:0]        addr;
  logic [15:0]        wrdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bbox_draw dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .done    (done),
    .err     (err),
    .x_min   (x_min),
    .x_max   (x_max),
    .y_min   (y_min),
    .y_max   (y_max),
    .addr    (addr),
    .wrdata  (wrdata),
    .wren    (wren),
    .wr_ready(wr_ready)
  );

  logic [31:0] got_a[$];
  logic [15:0] got_d[$];
  int          n_wr, done_i, frz_bad;
  logic        err_end, done0, err0;
  bit          wren_seen, aborted, frz_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at(input int k);
    return (k >= 0 && k < got_a.size()) ? got_a[k] : 32'hFFFF_FFFF;
  endfunction

  // Starts one draw and logs every transfer until done rises (bounded).
  task automatic run_box(input int xl, input int xh, input int yl, input int yh,
                         input int stall_after, input int stall_len,
                         input int rst_at, input bit poke);
    int stall_left;
    logic [31:0] frz_a;
    logic [15:0] frz_d;
    stall_left = 0;
    got_a.delete();
    got_d.delete();
    n_wr = 0; done_i = -1; frz_bad = 0;
    wren_seen = 0; aborted = 0; frz_valid = 0;
    @(posedge clk); #1;
    x_min = COORD_W'(xl); x_max = COORD_W'(xh);
    y_min = COORD_W'(yl); y_max = COORD_W'(yh);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = 1'b1;
      end
      #1;
      if (i == 0) begin
        done0 = done;
        err0  = err;
      end
      if (!wr_ready) begin
        if (!frz_valid) begin
          frz_a = addr; frz_d = wrdata; frz_valid = 1;
        end else if (addr !== frz_a || wrdata !== frz_d || wren !== 1'b1) begin
          frz_bad++;
        end
      end
      if (done && i > 0) begin
        done_i  = i;
        err_end = err;
        break;
      end
      if (wren) wren_seen = 1;
      if (poke && n_wr == 5) begin
        start = 1'b1; x_min = '0; x_max = 11'd99;
      end else begin
        start = 1'b0;
      end
      if (wren && wr_ready) begin
        got_a.push_back(addr);
        got_d.push_back(wrdata);
        n_wr++;
        if (n_wr == stall_after) stall_left = stall_len;
        if (n_wr == rst_at) begin
          rst_n = 1'b0;
          @(negedge clk); #1;
          check("rst_mid_wren", 32'(wren), 0);
          check("rst_mid_done", 32'(done), 0);
          check("rst_mid_addr", addr, 0);
          rst_n   = 1'b1;
          aborted = 1;
          break;
        end
      end
    end
    wr_ready = 1'b1;
    start    = 1'b0;
  endtask

  // Independent reference: visit box pixels row by row and keep outline ones.
  task automatic verify(input string tag, input int xl, input int xh, input int yl, input int yh,
                        input int stall);
    logic [31:0] ea[$];
    logic [15:0] ed[$];
    int cxl, cxh, cyl, cyh, seq_bad;
    bit inval;
    cxl = (xl > W-1) ? W-1 : xl;
    cxh = (xh > W-1) ? W-1 : xh;
    cyl = (yl > H-1) ? H-1 : yl;
    cyh = (yh > H-1) ? H-1 : yh;
    inval = (cxl > cxh) || (cyl > cyh);
    if (!inval) begin
      for (int yy = cyl; yy <= cyh; yy++)
        for (int xx = cxl; xx <= cxh; xx++)
          if (FILL || yy == cyl || yy == cyh || xx == cxl || xx == cxh)
            for (int cc = 0; cc < 3; cc++) begin
              ea.push_back(32'((H-1-yy)*W*3 + xx*3 + cc));
              ed.push_back((cc == 2) ? 16'h00FF : 16'h0000);
            end
    end
    seq_bad = 0;
    for (int k = 0; k < ea.size(); k++)
      if (k >= got_a.size() || got_a[k] !== ea[k] || got_d[k] !== ed[k]) seq_bad++;
    check({tag, "_count"}, n_wr, ea.size());
    check({tag, "_seq"}, seq_bad, 0);
    check({tag, "_done_cycle"}, done_i, ea.size() + 1 + stall);
    check({tag, "_err"}, 32'(err_end), 32'(inval));
    check({tag, "_start_clears"}, {done0, err0}, 0);
  endtask

  initial begin
    int centre;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    check("reset_wren", 32'(wren), 0);
    check("reset_addr", addr, 0);
    check("reset_wrdata", 32'(wrdata), 0);
    rst_n = 1'b1;

    // 3x3 box with a start pulse mid-draw that must be ignored
    run_box(10, 12, 20, 22, 0, 0, 0, 1);
    verify("box3", 10, 12, 20, 22, 0);
    check("box3_first_addr", at(0), 23730);
    check("box3_first_data", (got_d.size() > 0) ? 32'(got_d[0]) : 32'hFFFF, 32'h0000);
    check("box3_third_addr", at(2), 23732);
    check("box3_third_data", (got_d.size() > 2) ? 32'(got_d[2]) : 32'hFFFF, 32'h00FF);
    centre = 0;
    foreach (got_a[k]) if (got_a[k] >= 23433 && got_a[k] <= 23435) centre++;
    check("box3_centre", centre, FILL ? 3 : 0);

    run_box(0, 0, 0, 0, 0, 0, 0, 0);
    verify("pix", 0, 0, 0, 0, 0);
    check("pix_a0", at(0), 29700);
    check("pix_a2", at(2), 29702);

    run_box(10, 12, 20, 22, 7, 5, 0, 0);
    verify("stall", 10, 12, 20, 22, 5);
    check("stall_frozen", frz_bad, 0);
    check("stall_seen", 32'(frz_valid), 1);

    run_box(50, 40, 0, 0, 0, 0, 0, 0);
    verify("inval", 50, 40, 0, 0, 0);
    check("inval_no_wren", 32'(wren_seen), 0);

    run_box(0, 0, 0, 0, 0, 0, 0, 0);
    verify("after_inval", 0, 0, 0, 0, 0);

    run_box(98, 200, 0, 0, 0, 0, 0, 0);
    verify("clamp", 98, 200, 0, 0, 0);
    check("clamp_first", at(0), 29994);
    check("clamp_last", at(got_a.size() - 1), 29999);

    run_box(10, 12, 20, 22, 0, 0, 10, 0);
    check("rst_aborted", 32'(aborted), 1);
    run_box(10, 12, 20, 22, 0, 0, 0, 0);
    verify("restart", 10, 12, 20, 22, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
